// File: rtl/alu_writeback_if.sv
// ALU-result input handshake and register-file write port of the writeback stage.
// The slave modport is the writeback stage; master is the ALU / register-file side.
interface alu_writeback_if #(
   parameter int RF_ADDR_W = 3
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4:0]           in_op;
   logic                 in_size;
   logic [RF_ADDR_W-1:0] in_dst;
   logic                 in_dst_hi;
   logic                 in_cnt_zero;
   logic [15:0]          in_r;
   logic [5:0]           in_flags;
   logic                 rf_we;
   logic [RF_ADDR_W-1:0] rf_addr;
   logic [15:0]          rf_data;
   logic [1:0]           rf_be;
   logic                 rf_ready;

   modport slave (
      input  in_valid, in_op, in_size, in_dst, in_dst_hi, in_cnt_zero, in_r, in_flags, rf_ready,
      output in_ready, rf_we, rf_addr, rf_data, rf_be
   );

   modport master (
      output in_valid, in_op, in_size, in_dst, in_dst_hi, in_cnt_zero, in_r, in_flags, rf_ready,
      input  in_ready, rf_we, rf_addr, rf_data, rf_be
   );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: registers the result toward the register file with backpressure
// and maintains the architectural PSW (ALU flag policy, POPF load, CLC/STC/CMC).
module alu_writeback #(
   parameter int          RF_ADDR_W = 3,
   parameter logic [15:0] PSW_RESET = 16'hF002
) (
   input  logic               clk,
   input  logic               reset,
   alu_writeback_if.slave     bus,
   input  logic               psw_load,
   input  logic [15:0]        psw_din,
   input  logic [1:0]         cf_op,
   output logic [15:0]        psw
);
   localparam logic [4:0] OP_ADD = 5'd0,  OP_OR = 5'd1,   OP_ADDC = 5'd2,  OP_NEG = 5'd3;
   localparam logic [4:0] OP_AND = 5'd4,  OP_SUB = 5'd5,  OP_XOR = 5'd6,   OP_CMP = 5'd7;
   localparam logic [4:0] OP_ROL = 5'd8,  OP_ROR = 5'd9,  OP_ROLC = 5'd10, OP_RORC = 5'd11;
   localparam logic [4:0] OP_SHL = 5'd12, OP_SHR = 5'd13, OP_SHRA = 5'd14, OP_SHLA = 5'd15;
   localparam logic [4:0] OP_INC = 5'd16, OP_DEC = 5'd17;

   // Writable PSW bits; everything else is forced to the fixed pattern.
   localparam logic [15:0] PSW_MASK  = 16'h0FD5;
   localparam logic [15:0] PSW_FIXED = 16'hF002;

   localparam int P_CY = 0, P_P = 2, P_AC = 4, P_Z = 6, P_S = 7, P_V = 11;

   logic                 rf_we_q,   rf_we_d;
   logic [RF_ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [15:0]          rf_data_q, rf_data_d;
   logic [1:0]           rf_be_q,   rf_be_d;
   logic [15:0]          psw_q,     psw_d;
   logic [15:0]          psw_n;
   logic                 accept;
   logic                 writes_rf;
   logic                 f_ac, f_cy, f_v, f_p, f_s, f_z;

   assign bus.in_ready = !rf_we_q || bus.rf_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign writes_rf    = (bus.in_op != OP_CMP) && (bus.in_op <= OP_DEC);

   assign {f_z, f_s, f_p, f_v, f_cy, f_ac} = bus.in_flags;

   always_comb begin
      rf_we_d   = rf_we_q;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      rf_be_d   = rf_be_q;
      if (accept) begin
         rf_we_d = writes_rf;
         if (writes_rf) begin
            rf_addr_d = bus.in_dst;
            if (bus.in_size) begin
               rf_data_d = bus.in_r;
               rf_be_d   = 2'b11;
            end else begin
               rf_data_d = {bus.in_r[7:0], bus.in_r[7:0]};
               rf_be_d   = bus.in_dst_hi ? 2'b10 : 2'b01;
            end
         end
      end else if (bus.rf_ready) begin
         rf_we_d = 1'b0;
      end
   end

   // One PSW source per cycle: load beats ALU flags beats carry ops.
   always_comb begin
      psw_n = psw_q;
      if (psw_load) begin
         psw_n = psw_din;
      end else if (accept) begin
         unique case (bus.in_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_NEG, OP_CMP: begin
               psw_n[P_AC] = f_ac; psw_n[P_CY] = f_cy; psw_n[P_V] = f_v;
               psw_n[P_P]  = f_p;  psw_n[P_S]  = f_s;  psw_n[P_Z] = f_z;
            end
            OP_OR, OP_AND, OP_XOR: begin
               psw_n[P_AC] = 1'b0; psw_n[P_CY] = 1'b0; psw_n[P_V] = 1'b0;
               psw_n[P_P]  = f_p;  psw_n[P_S]  = f_s;  psw_n[P_Z] = f_z;
            end
            OP_ROL, OP_ROR, OP_ROLC, OP_RORC: begin
               if (!bus.in_cnt_zero) begin
                  psw_n[P_CY] = f_cy; psw_n[P_V] = f_v;
               end
            end
            OP_SHL, OP_SHR, OP_SHRA, OP_SHLA: begin
               if (!bus.in_cnt_zero) begin
                  psw_n[P_CY] = f_cy; psw_n[P_V] = f_v;
                  psw_n[P_P]  = f_p;  psw_n[P_S] = f_s; psw_n[P_Z] = f_z;
               end
            end
            OP_INC, OP_DEC: begin
               psw_n[P_AC] = f_ac; psw_n[P_V] = f_v;
               psw_n[P_P]  = f_p;  psw_n[P_S] = f_s; psw_n[P_Z] = f_z;
            end
            default: ;
         endcase
      end else begin
         unique case (cf_op)
            2'b01:   psw_n[P_CY] = 1'b0;
            2'b10:   psw_n[P_CY] = 1'b1;
            2'b11:   psw_n[P_CY] = ~psw_q[P_CY];
            default: ;
         endcase
      end
      psw_d = (psw_n & PSW_MASK) | PSW_FIXED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         rf_be_q   <= '0;
         psw_q     <= PSW_RESET;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         rf_be_q   <= rf_be_d;
         psw_q     <= psw_d;
      end
   end

   assign bus.rf_we   = rf_we_q;
   assign bus.rf_addr = rf_addr_q;
   assign bus.rf_data = rf_data_q;
   assign bus.rf_be   = rf_be_q;
   assign psw         = psw_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback: register-file writes go through a queue
// checked by a monitor; PSW and handshake values are checked inline.
module tb_alu_writeback;
   logic        clk = 1'b0;
   logic        reset;
   logic        psw_load;
   logic [15:0] psw_din;
   logic [1:0]  cf_op;
   logic [15:0] psw;

   alu_writeback_if #(.RF_ADDR_W(3)) bus ();

   alu_writeback #(.RF_ADDR_W(3), .PSW_RESET(16'hF002)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .psw_load (psw_load),
      .psw_din  (psw_din),
      .cf_op    (cf_op),
      .psw      (psw)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every completed register-file write must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.rf_we && bus.rf_ready) begin
         wr_t got, want;
         got = '{bus.rf_addr, bus.rf_data, bus.rf_be};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rf_write: unexpected write %h", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               n_bad++;
               $display("FAIL rf_write: got %h, expected %h", got, want);
            end
         end
      end
   end

   // Present one result and hold it until accepted; returns #1 after the accept edge.
   task automatic issue(input logic [4:0] op, input logic size, input logic [2:0] dst,
                        input logic hi, input logic cz, input logic [15:0] r,
                        input logic [5:0] flags, input logic push, input wr_t exp_wr);
      bit done = 0;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_size = size; bus.in_dst = dst;
      bus.in_dst_hi = hi; bus.in_cnt_zero = cz; bus.in_r = r; bus.in_flags = flags;
      if (push) exp_q.push_back(exp_wr);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_vec++; n_bad++;
         $display("FAIL accept_timeout: op %0d never accepted", op);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; psw_load = 1'b0; psw_din = '0; cf_op = 2'b00;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_size = 1'b0; bus.in_dst = '0;
      bus.in_dst_hi = 1'b0; bus.in_cnt_zero = 1'b0; bus.in_r = '0; bus.in_flags = '0;
      bus.rf_ready = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_psw", psw, 16'hF002);
      chk("reset_rf_we", bus.rf_we, 1'b0);
      chk("reset_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;

      // ADD word: Z, P, CY set
      issue(5'd0, 1, 3'd0, 0, 0, 16'h0000, 6'b101010, 1, '{3'd0, 16'h0000, 2'b11});
      @(negedge clk);
      chk("add_latency_rf_we", bus.rf_we, 1'b1);
      chk("add_psw", psw, 16'hF047);
      @(posedge clk); #1;

      // XOR byte to high half: CY/V/AC cleared
      issue(5'd6, 0, 3'd2, 1, 0, 16'h12F0, 6'b111111, 1, '{3'd2, 16'hF0F0, 2'b10});
      @(negedge clk);
      chk("xor_psw", psw, 16'hF0C6);
      @(posedge clk); #1;

      cf_op = 2'b10;
      idle(1);
      cf_op = 2'b00;
      @(negedge clk);
      chk("stc_psw", psw, 16'hF0C7);
      @(posedge clk); #1;

      // INC byte low: CY kept
      issue(5'd16, 0, 3'd3, 0, 0, 16'h0055, 6'b000000, 1, '{3'd3, 16'h5555, 2'b01});
      @(negedge clk);
      chk("inc_psw", psw, 16'hF003);
      @(posedge clk); #1;
      idle(2);

      // Backpressure: A written but stalled, B held at input
      bus.rf_ready = 1'b0;
      issue(5'd0, 1, 3'd1, 0, 0, 16'h1234, 6'b000001, 1, '{3'd1, 16'h1234, 2'b11});
      bus.in_valid = 1'b1; bus.in_op = 5'd0; bus.in_size = 1'b1; bus.in_dst = 3'd4;
      bus.in_r = 16'hABCD; bus.in_flags = 6'b100000;
      exp_q.push_back('{3'd4, 16'hABCD, 2'b11});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", bus.in_ready, 1'b0);
         chk("stall_rf_data", bus.rf_data, 16'h1234);
         chk("stall_psw", psw, 16'hF012);
         @(posedge clk); #1;
      end
      bus.rf_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("second_add_data", bus.rf_data, 16'hABCD);
      chk("second_add_psw", psw, 16'hF042);
      @(posedge clk); #1;

      psw_load = 1'b1; psw_din = 16'h0000;
      idle(1);
      psw_load = 1'b0;
      @(negedge clk);
      chk("popf_zero_psw", psw, 16'hF002);
      @(posedge clk); #1;

      // SHL with zero count: write happens, flags untouched
      issue(5'd12, 1, 3'd5, 0, 1, 16'h8000, 6'b111111, 1, '{3'd5, 16'h8000, 2'b11});
      @(negedge clk);
      chk("shl_cz_psw", psw, 16'hF002);
      chk("shl_cz_rf_we", bus.rf_we, 1'b1);
      @(posedge clk); #1;

      issue(5'd7, 1, 3'd6, 0, 0, 16'h5A5A, 6'b111111, 0, '0);
      @(negedge clk);
      chk("cmp_psw", psw, 16'hF8D7);
      chk("cmp_no_rf_we", bus.rf_we, 1'b0);
      @(posedge clk); #1;

      // POPF + ADD + CLC in one cycle: load wins, write still occurs
      psw_load = 1'b1; psw_din = 16'hFFFF; cf_op = 2'b01;
      issue(5'd0, 1, 3'd6, 0, 0, 16'h0F0F, 6'b000000, 1, '{3'd6, 16'h0F0F, 2'b11});
      psw_load = 1'b0; cf_op = 2'b00;
      @(negedge clk);
      chk("popf_priority_psw", psw, 16'hFFD7);
      chk("popf_add_rf_we", bus.rf_we, 1'b1);
      @(posedge clk); #1;
      idle(1);

      // Reset with a stalled pending write drops it
      bus.rf_ready = 1'b0;
      issue(5'd0, 1, 3'd7, 0, 0, 16'hDEAD, 6'b000000, 0, '0);
      @(negedge clk);
      chk("pending_rf_we", bus.rf_we, 1'b1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_drop_rf_we", bus.rf_we, 1'b0);
      chk("reset_drop_psw", psw, 16'hF002);
      bus.rf_ready = 1'b1;
      idle(2);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Pipeline stage directly downstream of the ALU.
- Latches the ALU result and raw flags.
- Applies the per-opcode flag-update policy to the architectural PSW.
- Merges byte/word results and drives the register-file write port with backpressure.
- Also owns PSW load (POPF) and the carry-flag ops CLC/STC/CMC.

Parameters:
RF_ADDR_W, 3, width of register index (8 word registers)
PSW_RESET, 16'hF002, PSW value after reset (bit1 and bits 15:12 fixed at 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  ALU result valid
in_ready  out  1  stage can accept a result this cycle
in_op  in  5  ALU opcode: ADD=0 OR=1 ADDC=2 NEG=3 AND=4 SUB=5 XOR=6 CMP=7 ROL=8 ROR=9 ROLC=10 RORC=11 SHL=12 SHR=13 SHRA=14 SHLA=15 INC=16 DEC=17
in_size  in  1  0=byte, 1=word
in_dst  in  RF_ADDR_W  destination word-register index
in_dst_hi  in  1  byte ops only: 1 = high byte of in_dst
in_cnt_zero  in  1  shift/rotate count was zero
in_r  in  16  ALU result
in_flags  in  6  ALU flags, index AC=0 CY=1 V=2 P=3 S=4 Z=5
psw_load  in  1  load PSW from psw_din
psw_din  in  16  PSW load value
cf_op  in  2  00 none, 01 CLC, 10 STC, 11 CMC
psw  out  16  architectural PSW: CY=0 P=2 AC=4 Z=6 S=7 BRK=8 IE=9 DIR=10 V=11
rf_we  out  1  register write valid
rf_addr  out  RF_ADDR_W  write register index
rf_data  out  16  write data
rf_be  out  2  byte enables, [1]=high byte
rf_ready  in  1  register file accepts the write

Behaviour:
Reset values:
- psw=PSW_RESET.
- rf_we=0, rf_addr=0, rf_data=0, rf_be=0.
- in_ready=1.
- A pending write is dropped on reset, even mid-transfer.

Handshake:
- Accept when in_valid && in_ready.
- in_ready = !rf_we || rf_ready, combinational.
- rf_we holds, with rf_addr/rf_data/rf_be stable, until rf_ready=1.
- Latency: accept at edge N, so rf_we=1 in cycle N+1.
- Throughput: 1 result per cycle when rf_ready=1.

Result formatting, registered at accept:
- size=1: rf_data=in_r, rf_be=11.
- size=0: rf_data={in_r[7:0],in_r[7:0]}, rf_be=10 if in_dst_hi else 01.
- CMP and opcodes 18..31: update flags per policy (18..31 update none), do not set rf_we. in_ready still follows the rule above.

Flag policy, applied to psw at the accept edge. Flags not listed are unchanged.
- ADD/ADDC/SUB/NEG/CMP: AC, CY, V, P, S, Z from in_flags.
- OR/AND/XOR: P, S, Z from in_flags; CY=0, V=0, AC=0.
- ROL/ROR/ROLC/RORC: CY and V only.
- SHL/SHR/SHRA/SHLA: CY, V, P, S, Z; AC unchanged.
- Any shift/rotate with in_cnt_zero=1: no flag change. The result is still written (word/byte as above).
- INC/DEC: AC, V, P, S, Z; CY unchanged.

PSW writes other than the ALU:
- psw_load: psw <= (psw_din & 16'h0FD5) | 16'hF002.
- cf_op acts on CY only. CLC: CY<=0. STC: CY<=1. CMC: CY<=~CY, using the current registered CY.

Priority in one cycle: psw_load > ALU accept flag update > cf_op.
- A lower-priority PSW source is discarded for that cycle.
- The ALU result write itself is never suppressed by psw_load.

Stall rules:
- PSW updates only on the accept edge, never while a result is stalled at the input.
- A result held in the output register has already committed its flags.

Fixed bits: psw[1]=1, psw[15:12]=1111, psw[3]=psw[5]=0 at all times.

Test Plan:
- Reset asserted 2 cycles -> psw=F002, rf_we=0, in_ready=1. Reset while rf_we=1 and rf_ready=0 -> rf_we=0 the next cycle.
- ADD, size=1, in_r=0000, in_flags=101010, dst=0 -> cycle N+1: rf_we=1, rf_addr=0, rf_data=0000, rf_be=11; psw=F047.
- XOR, size=0, dst_hi=1, in_r=12F0, in_flags=111111 -> rf_data=F0F0, rf_be=10, psw=F0C6. Then STC -> psw=F0C7. Then INC with in_flags=000000 -> psw=F003 (CY kept).
- rf_ready=0 for 3 cycles with a write pending and a second ADD presented -> in_ready=0, rf_data stable, psw unchanged. When rf_ready=1, the first write completes and the second ADD is accepted that cycle.
- SHL, in_cnt_zero=1, in_flags=111111, psw=F002 -> psw stays F002, rf_we=1.
- CMP -> flags update, no rf_we.
- psw_load=1 with psw_din=FFFF, same cycle as an accepted ADD with in_flags=000000, and cf_op=CLC -> psw=FFD7, and the ADD write still occurs.
